// File: rtl/mux_arbiter.sv
// Two-requester round-robin arbiter driving a shared 2:1 mux select.
// Define MUX_ARBITER_TIMEOUT_EN to force a hand-over after MAX_HOLD grant cycles under contention.
module mux_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic req_x,
    input  logic req_y,
    input  logic x,
    input  logic y,
    output logic gnt_x,
    output logic gnt_y,
    output logic s,
    output logic m,
    output logic valid,
    output logic preempt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_X = 2'd1,
        GNT_Y = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     state;
    state_t     state_nxt;
    logic       last_y;
    logic [7:0] hold_cnt;
    logic       at_limit;
    logic       force_sw;
    logic       grant_entry;

`ifdef MUX_ARBITER_TIMEOUT_EN
    assign at_limit = (hold_cnt == HOLD_LAST);
`else
    assign at_limit = 1'b0;
`endif

    // NOTE: every output of this block is given a default first so no path leaves a latch.
    always_comb begin
        state_nxt = state;
        force_sw  = 1'b0;
        case (state)
            IDLE: begin
                if (req_x && req_y)
                    state_nxt = last_y ? GNT_X : GNT_Y;
                else if (req_x)
                    state_nxt = GNT_X;
                else if (req_y)
                    state_nxt = GNT_Y;
            end
            GNT_X: begin
                if (!req_x)
                    state_nxt = req_y ? GNT_Y : IDLE;
                else if (at_limit && req_y) begin
                    state_nxt = GNT_Y;
                    force_sw  = 1'b1;
                end
            end
            GNT_Y: begin
                if (!req_y)
                    state_nxt = req_x ? GNT_X : IDLE;
                else if (at_limit && req_x) begin
                    state_nxt = GNT_X;
                    force_sw  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A grant state is only ever entered from IDLE or from the other grant state.
    assign grant_entry = (state_nxt != IDLE) && (state_nxt != state);

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            last_y   <= 1'b1;
            hold_cnt <= 8'd0;
            s        <= 1'b0;
            preempt  <= 1'b0;
        end else begin
            state   <= state_nxt;
            preempt <= force_sw;
            if (grant_entry) begin
                hold_cnt <= 8'd0;
                s        <= (state_nxt == GNT_Y);
                last_y   <= (state_nxt == GNT_Y);
            end else if (state != IDLE && hold_cnt != HOLD_LAST) begin
                hold_cnt <= hold_cnt + 8'd1;
            end
        end
    end

    assign gnt_x = (state == GNT_X);
    assign gnt_y = (state == GNT_Y);
    assign valid = gnt_x | gnt_y;
    assign m     = (~s & x) | (s & y);

endmodule

// File: doc/mux_arbiter.md
MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 Parameter: MAX_HOLD, default 8, maximum consecutive grant cycles before forced hand-over (range 2..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req_x  input  1  requester X wants the shared mux output; level, held while using it.
REQ-005 req_y  input  1  requester Y wants the shared mux output; level, held while using it.
REQ-006 x  input  1  requester X data bit, routed to m while X granted.
REQ-007 y  input  1  requester Y data bit, routed to m while Y granted.
REQ-008 gnt_x  output  1  registered grant to X.
REQ-009 gnt_y  output  1  registered grant to Y.
REQ-010 s  output  1  select driven to the 2:1 mux (0 = x, 1 = y).
REQ-011 m  output  1  shared output: (~s & x) | (s & y), combinational.
REQ-012 valid  output  1  gnt_x | gnt_y; m is meaningful only when high.
REQ-013 preempt  output  1  one-cycle pulse on a forced hand-over.

Function
REQ-014 FSM states: IDLE, GNT_X, GNT_Y; gnt_x = (state==GNT_X), gnt_y = (state==GNT_Y), both registered.
REQ-015 gnt_x and gnt_y never high in the same cycle.
REQ-016 last_y flag records the last served requester; set on entry to GNT_Y, cleared on entry to GNT_X.
REQ-017 IDLE, req_x only -> GNT_X; req_y only -> GNT_Y; none -> stay IDLE.
REQ-018 IDLE, both requesting -> the requester not last served (last_y=1 -> GNT_X, last_y=0 -> GNT_Y).
REQ-019 Grant latency: request sampled high in IDLE at edge N -> grant high after edge N.
REQ-020 GNT_X: req_x low -> GNT_Y if req_y high, else IDLE; no idle bubble on direct hand-over. GNT_Y symmetric.
REQ-021 GNT_X/GNT_Y with own request still high and no preemption -> stay.
REQ-022 s: 0 in GNT_X, 1 in GNT_Y, holds previous value in IDLE; s changes only on the same edge as the grant.
REQ-023 hold_cnt (8 bit) clears on every grant entry, increments each cycle in a grant state, saturates at MAX_HOLD-1.
REQ-024 Request dropping and reasserting in consecutive cycles is treated as a new request (re-arbitrated per REQ-018/020).
REQ-025 preempt is 0 except per REQ-031.

Reset
REQ-026 On reset assertion, immediately (no clock edge): state=IDLE, gnt_x=0, gnt_y=0, valid=0, s=0, preempt=0, hold_cnt=0, last_y=1 (X wins first tie).
REQ-027 Reset mid-grant drops grant asynchronously; no preempt pulse generated.
REQ-028 After reset release, first edge evaluates requests as from IDLE.

Configuration
REQ-029 Macro MUX_ARBITER_TIMEOUT_EN selects forced hand-over.
REQ-030 Without it: no preemption; a grant holds as long as its request stays high; hold_cnt still counts; preempt tied 0.
REQ-031 With it: in GNT_X with hold_cnt==MAX_HOLD-1, req_x high and req_y high -> GNT_Y next edge, preempt=1 for that one cycle; GNT_Y symmetric; other requester idle -> no switch, counter stays saturated.

Verification
REQ-032 Reset, then req_x=1 only -> gnt_x=1,s=0 after first edge; x toggling appears on m, valid=1.
REQ-033 Reset, req_x=req_y=1 same edge -> gnt_x first; drop req_x -> gnt_y next edge, s=1, no IDLE cycle.
REQ-034 Alternating ties: X served then IDLE, both request again -> gnt_y wins (last_y=0).
REQ-035 TIMEOUT_EN, MAX_HOLD=4, both held high -> gnt_x 4 cycles, gnt_y 4 cycles, preempt pulse at each switch; without macro gnt_x held indefinitely, preempt=0.
REQ-036 Assert reset during GNT_Y -> gnt_y=0, s=0 before next edge; release with req_y only -> gnt_y after first edge.
